// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the PC generator and its upstream/downstream neighbours.
// The slave modport is the PC generator's own view of the bundle.
interface pc_gen_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall_i;
  logic                branch_taken_i;
  logic [PC_WIDTH-1:0] branch_target_i;
  logic [31:0]         instr_i;
  logic [PC_WIDTH-1:0] pc_o;
  logic                isstall_o;
  logic                halted_o;
  logic [31:0]         fetch_count_o;

  modport master (
    output stall_i, branch_taken_i, branch_target_i, instr_i,
    input  pc_o, isstall_o, halted_o, fetch_count_o
  );

  modport slave (
    input  stall_i, branch_taken_i, branch_target_i, instr_i,
    output pc_o, isstall_o, halted_o, fetch_count_o
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator feeding instruction fetch: sequential advance, stall hold,
// branch redirect with a fixed bubble count, halt on opcode 4'hF, saturating fetch counter.
//
// state   | meaning
// S_RUN   | fetching pc_o this cycle
// S_HOLD  | stalled by decode/execute, pc_o refetched once released
// S_FLUSH | bubbles after a taken branch, flush_cnt_q cycles remaining
// S_HALT  | halt opcode seen, frozen until reset
module pc_gen #(
  parameter int PC_WIDTH     = 32,
  parameter int RESET_PC     = 0,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_WORDS    = 262144
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [PC_WIDTH-1:0] PC_MASK    = PC_WIDTH'(MEM_WORDS - 1);
  localparam logic [PC_WIDTH-1:0] PC_RESET   = PC_WIDTH'(RESET_PC) & PC_MASK;
  localparam logic [3:0]          FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]          flush_cnt_q, flush_cnt_d;
  logic [31:0]         fetch_cnt_q, fetch_cnt_d;

  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] pc_target;
  logic [31:0]         fetch_cnt_inc;
  state_e              branch_state;
  logic                halt_op;

  // Only the opcode nibble matters here; the rest of the word belongs to decode.
  logic unused_instr;
  assign unused_instr = ^bus.instr_i[27:0];

  assign pc_seq        = (pc_q + PC_WIDTH'(1)) & PC_MASK;
  assign pc_target     = bus.branch_target_i & PC_MASK;
  assign fetch_cnt_inc = (&fetch_cnt_q) ? fetch_cnt_q : fetch_cnt_q + 32'd1;
  assign halt_op       = (bus.instr_i[31:28] == 4'b1111);
  assign branch_state  = (FLUSH_CYCLES > 0) ? S_FLUSH : S_RUN;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pc_q        <= PC_RESET;
      flush_cnt_q <= 4'd0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      S_RUN: begin
        if (bus.branch_taken_i) begin
          state_d     = branch_state;
          pc_d        = pc_target;
          flush_cnt_d = FLUSH_INIT;
        end else if (halt_op) begin
          state_d = S_HALT;
        end else if (bus.stall_i) begin
          state_d     = S_HOLD;
          fetch_cnt_d = fetch_cnt_inc;
        end else begin
          pc_d        = pc_seq;
          fetch_cnt_d = fetch_cnt_inc;
        end
      end
      S_HOLD: begin
        if (bus.branch_taken_i) begin
          state_d     = branch_state;
          pc_d        = pc_target;
          flush_cnt_d = FLUSH_INIT;
        end else if (!bus.stall_i) begin
          state_d = S_RUN;
        end
      end
      S_FLUSH: begin
        if (bus.branch_taken_i) begin
          pc_d        = pc_target;
          flush_cnt_d = FLUSH_INIT;
        end else if (flush_cnt_q <= 4'd1) begin
          state_d     = bus.stall_i ? S_HOLD : S_RUN;
          flush_cnt_d = 4'd0;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.pc_o          = pc_q;
    bus.isstall_o     = (state_q != S_RUN);
    bus.halted_o      = (state_q == S_HALT);
    bus.fetch_count_o = fetch_cnt_q;
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations plus a
// randomized run compared against a cycle-level behavioural model.
module tb_pc_gen;
  localparam int  MEM = 262144;
  localparam int  FC  = 2;
  localparam logic [31:0] HALT_W = 32'hF000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  longint m_pc;
  longint m_count;
  int     m_bubbles;
  bit     m_waiting;
  bit     m_halted;

  pc_gen_if #(.PC_WIDTH(32)) bus ();

  pc_gen #(
    .PC_WIDTH(32), .RESET_PC(0), .FLUSH_CYCLES(FC), .MEM_WORDS(MEM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Applies one cycle of inputs, advances the reference model, samples 1 time unit after the edge.
  task automatic cyc(input bit st, input bit br, input logic [31:0] tgt, input logic [31:0] ins);
    bus.stall_i         = st;
    bus.branch_taken_i  = br;
    bus.branch_target_i = tgt;
    bus.instr_i         = ins;
    if (!rst_n) begin
      m_pc = 0; m_count = 0; m_bubbles = 0; m_waiting = 0; m_halted = 0;
    end else if (m_halted) begin
    end else if (br) begin
      m_pc = longint'(tgt) % MEM;
      m_bubbles = FC;
      m_waiting = 0;
    end else if (m_bubbles > 0) begin
      m_bubbles--;
      if (m_bubbles == 0) m_waiting = st;
    end else if (m_waiting) begin
      m_waiting = st;
    end else if (ins[31:28] == 4'hF) begin
      m_halted = 1;
    end else begin
      if (m_count < 64'hFFFF_FFFF) m_count++;
      if (st) m_waiting = 1;
      else m_pc = (m_pc + 1) % MEM;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.pc_o !== 32'd0) begin errors++; $display("FAIL reset_pc got %0h want 0", bus.pc_o); end
    checks++; if (bus.isstall_o !== 1'b0) begin errors++; $display("FAIL reset_isstall got %b want 0", bus.isstall_o); end
    checks++; if (bus.halted_o !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus.halted_o); end
    checks++; if (bus.fetch_count_o !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.fetch_count_o); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 32'h0000_0001);
      checks++;
      if (bus.pc_o !== 32'(i) || bus.isstall_o !== 1'b0) begin
        errors++; $display("FAIL seq_pc got pc=%0d isstall=%b want pc=%0d isstall=0", bus.pc_o, bus.isstall_o, i);
      end
    end
    checks++; if (bus.fetch_count_o !== 32'd5) begin errors++; $display("FAIL seq_count got %0d want 5", bus.fetch_count_o); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h40, 0);
    checks++; if (bus.pc_o !== 32'h40 || bus.isstall_o !== 1'b1) begin errors++; $display("FAIL br_bubble1 got pc=%0h isstall=%b want pc=40 isstall=1", bus.pc_o, bus.isstall_o); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pc_o !== 32'h40 || bus.isstall_o !== 1'b1) begin errors++; $display("FAIL br_bubble2 got pc=%0h isstall=%b want pc=40 isstall=1", bus.pc_o, bus.isstall_o); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pc_o !== 32'h40 || bus.isstall_o !== 1'b0) begin errors++; $display("FAIL br_resume got pc=%0h isstall=%b want pc=40 isstall=0", bus.pc_o, bus.isstall_o); end
    checks++; if (bus.fetch_count_o !== 32'd3) begin errors++; $display("FAIL br_count_hold got %0d want 3", bus.fetch_count_o); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pc_o !== 32'h41 || bus.fetch_count_o !== 32'd4) begin errors++; $display("FAIL br_after got pc=%0h count=%0d want pc=41 count=4", bus.pc_o, bus.fetch_count_o); end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (8) cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      checks++;
      if (bus.pc_o !== 32'd8 || bus.isstall_o !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got pc=%0d isstall=%b want pc=8 isstall=1", i, bus.pc_o, bus.isstall_o);
      end
    end
    checks++; if (bus.fetch_count_o !== 32'd9) begin errors++; $display("FAIL stall_count got %0d want 9", bus.fetch_count_o); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pc_o !== 32'd8 || bus.isstall_o !== 1'b0) begin errors++; $display("FAIL stall_release got pc=%0d isstall=%b want pc=8 isstall=0", bus.pc_o, bus.isstall_o); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pc_o !== 32'd9 || bus.fetch_count_o !== 32'd10) begin errors++; $display("FAIL stall_next got pc=%0d count=%0d want pc=9 count=10", bus.pc_o, bus.fetch_count_o); end
  endtask

  task automatic test_halt();
    do_reset();
    repeat (5) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, HALT_W);
    checks++; if (bus.halted_o !== 1'b1 || bus.isstall_o !== 1'b1 || bus.pc_o !== 32'd5) begin
      errors++; $display("FAIL halt_enter got halted=%b isstall=%b pc=%0d want 1 1 5", bus.halted_o, bus.isstall_o, bus.pc_o);
    end
    cyc(0, 1, 32'h99, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (bus.halted_o !== 1'b1 || bus.pc_o !== 32'd5 || bus.fetch_count_o !== 32'd5) begin
      errors++; $display("FAIL halt_frozen got halted=%b pc=%0d count=%0d want 1 5 5", bus.halted_o, bus.pc_o, bus.fetch_count_o);
    end
  endtask

  task automatic test_branch_vs_halt();
    do_reset();
    cyc(0, 1, 32'h10, HALT_W);
    checks++; if (bus.pc_o !== 32'h10 || bus.isstall_o !== 1'b1 || bus.halted_o !== 1'b0) begin
      errors++; $display("FAIL br_vs_halt got pc=%0h isstall=%b halted=%b want 10 1 0", bus.pc_o, bus.isstall_o, bus.halted_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(0, 1, 32'd262145, 0);
    checks++; if (bus.pc_o !== 32'd1) begin errors++; $display("FAIL wrap_target got %0d want 1", bus.pc_o); end
    cyc(0, 1, 32'd262143, 0);
    repeat (2) cyc(0, 0, 0, 0);
    checks++; if (bus.pc_o !== 32'd262143 || bus.isstall_o !== 1'b0) begin errors++; $display("FAIL wrap_top got pc=%0d isstall=%b want 262143 0", bus.pc_o, bus.isstall_o); end
    cyc(0, 0, 0, 0);
    checks++; if (bus.pc_o !== 32'd0) begin errors++; $display("FAIL wrap_seq got %0d want 0", bus.pc_o); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h123, 0);
    rst_n = 1'b0;
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    checks++; if (bus.pc_o !== 32'd0 || bus.isstall_o !== 1'b0 || bus.fetch_count_o !== 32'd0 || bus.halted_o !== 1'b0) begin
      errors++; $display("FAIL rst_flush got pc=%0h isstall=%b count=%0d halted=%b want 0 0 0 0", bus.pc_o, bus.isstall_o, bus.fetch_count_o, bus.halted_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    logic [31:0] ins;
    bit st, br;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      st  = ($urandom_range(99) < 25);
      br  = ($urandom_range(99) < 8);
      tgt = ($urandom_range(3) == 0) ? 32'(MEM - 3 + $urandom_range(5)) : $urandom;
      ins = ($urandom_range(99) < 2) ? (HALT_W | ($urandom & 32'h0FFF_FFFF)) : ($urandom & 32'h7FFF_FFFF);
      cyc(st, br, tgt, ins);
      rst_n = 1'b1;
      checks++;
      if (bus.pc_o !== 32'(m_pc) || bus.fetch_count_o !== 32'(m_count)) begin
        errors++; $display("FAIL rnd_pc_count n=%0d got pc=%0h count=%0d want pc=%0h count=%0d", n, bus.pc_o, bus.fetch_count_o, m_pc, m_count);
      end
      checks++;
      if (bus.isstall_o !== (m_halted || m_waiting || m_bubbles > 0) || bus.halted_o !== m_halted) begin
        errors++; $display("FAIL rnd_flags n=%0d got isstall=%b halted=%b want isstall=%b halted=%b", n, bus.isstall_o, bus.halted_o, (m_halted || m_waiting || m_bubbles > 0), m_halted);
      end
    end
  endtask

  initial begin
    bus.stall_i = 0; bus.branch_taken_i = 0; bus.branch_target_i = 0; bus.instr_i = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_halt();
    test_branch_vs_halt();
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
